// File: rtl/pingpong_pkg.sv
// ==== pingpong_pkg -- shared write-FSM state, default frame size and bank encodings (rev 1.0) ====
`default_nettype none

package pingpong_pkg;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_CAPTURE = 2'd1,
    W_END     = 2'd2
  } wr_state_t;

  localparam int FRAME_PIXELS_DEFAULT = 76800;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cmos_edge_det.sv
// ==== cmos_edge_det -- registers the frame vsync and emits one-cycle rise/fall pulses (rev 1.0) ====
`default_nettype none

module cmos_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic rise,
  output logic fall
);

  logic vsync_q;
  logic vsync_d;

  // Under reset both stages follow the pin, so a level held across reset is never seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= vsync_in;
      vsync_d <= vsync_in;
    end else begin
      vsync_q <= vsync_in;
      vsync_d <= vsync_q;
    end
  end

  assign rise = vsync_q & ~vsync_d;
  assign fall = ~vsync_q & vsync_d;

endmodule

`default_nettype wire

// File: rtl/pingpong_frame_arbiter.sv
// ==== pingpong_frame_arbiter -- ping-pong frame RAM arbiter between CMOS writer and one reader (rev 1.0) ====
// ==== Build option PINGPONG_DROP_CNT_EN: implements the saturating dropped-frame counter, else it reads 0 ====
`default_nettype none

module pingpong_frame_arbiter
  import pingpong_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                  cam_pclk,
  input  logic                  rst,
  input  logic                  cmos_frame_vsync,
  input  logic                  cmos_frame_href,
  input  logic                  cmos_frame_clken,
  input  logic [DATA_W-1:0]     cmos_frame_data,
  output logic                  ram_wr_en_0,
  output logic                  ram_wr_en_1,
  output logic [ADDR_W-1:0]     ram_wr_addr,
  output logic [DATA_W-1:0]     ram_wr_data,
  output logic                  ram_rd_sel,
  output logic [ADDR_W-1:0]     ram_rd_addr,
  input  logic                  rd_start,
  input  logic                  rd_en,
  output logic                  rd_busy,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [DROP_CNT_W-1:0] frame_drop_cnt
);

  // One extra bit so the count can reach FRAME_PIXELS even when it equals 2^ADDR_W.
  localparam logic [ADDR_W:0]   FRAME_LEN = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  wr_state_t       state;
  logic            wr_bank;
  logic [ADDR_W:0] pix_cnt;
  logic            overflow;

  logic vs_rise;
  logic vs_fall;

  logic pix_valid;
  logic pix_accept;
  logic good_frame;
  logic rd_start_acc;
  logic rd_last;
  logic reader_free;

  cmos_edge_det u_edge_det (
    .clk      (cam_pclk),
    .rst      (rst),
    .vsync_in (cmos_frame_vsync),
    .rise     (vs_rise),
    .fall     (vs_fall)
  );

  assign pix_valid    = (state == W_CAPTURE) & cmos_frame_href & cmos_frame_clken;
  assign pix_accept   = pix_valid & (pix_cnt < FRAME_LEN);
  assign good_frame   = (pix_cnt == FRAME_LEN) & ~overflow;
  assign rd_start_acc = rd_start & frame_valid & ~rd_busy;
  assign rd_last      = rd_en & rd_busy & (ram_rd_addr == LAST_ADDR);
  // A reader finishing this cycle frees its bank; one starting this cycle claims the other bank.
  assign reader_free  = (~rd_busy & ~rd_start_acc) | rd_last;

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      state       <= W_IDLE;
      wr_bank     <= BANK0;
      pix_cnt     <= '0;
      overflow    <= 1'b0;
      ram_wr_en_0 <= 1'b0;
      ram_wr_en_1 <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      ram_wr_en_0 <= pix_accept & (wr_bank == BANK0);
      ram_wr_en_1 <= pix_accept & (wr_bank == BANK1);
      frame_err   <= 1'b0;
      if (pix_accept) begin
        ram_wr_addr <= pix_cnt[ADDR_W-1:0];
        ram_wr_data <= cmos_frame_data;
      end
      if (rd_start_acc) begin
        frame_valid <= 1'b0;
      end
      case (state)
        W_IDLE: begin
          if (vs_rise) begin
            state    <= W_CAPTURE;
            pix_cnt  <= '0;
            overflow <= 1'b0;
          end
        end
        W_CAPTURE: begin
          if (pix_accept) begin
            pix_cnt <= pix_cnt + 1'b1;
          end else if (pix_valid) begin
            overflow <= 1'b1;
          end
          if (vs_fall) begin
            state <= W_END;
          end
        end
        W_END: begin
          if (!good_frame) begin
            frame_err <= 1'b1;
          end else if (reader_free) begin
            wr_bank     <= ~wr_bank;
            frame_valid <= 1'b1;
          end
          if (vs_rise) begin
            state    <= W_CAPTURE;
            pix_cnt  <= '0;
            overflow <= 1'b0;
          end else begin
            state <= W_IDLE;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      rd_busy     <= 1'b0;
      ram_rd_sel  <= BANK1;
      ram_rd_addr <= '0;
    end else if (rd_start_acc) begin
      rd_busy     <= 1'b1;
      ram_rd_sel  <= ~wr_bank;
      ram_rd_addr <= '0;
    end else if (rd_en && rd_busy) begin
      if (rd_last) begin
        rd_busy <= 1'b0;
      end else begin
        ram_rd_addr <= ram_rd_addr + 1'b1;
      end
    end
  end

`ifdef PINGPONG_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if ((state == W_END) && good_frame && !reader_free
                 && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign frame_drop_cnt = drop_cnt;
`else
  assign frame_drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pingpong_frame_arbiter.sv
// ==== tb_pingpong_frame_arbiter -- scoreboard bench for the ping-pong frame arbiter (rev 1.0) ====
`default_nettype none

module tb_pingpong_frame_arbiter;

  // Reduced frame length keeps every scenario short; all boundaries scale with it.
  localparam int FP     = 64;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int DCW    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              vsync, href, clken;
  logic [DATA_W-1:0] pix;
  logic              wr_en_0, wr_en_1;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_sel, rd_start, rd_en, rd_busy, frame_valid, frame_err;
  logic [DCW-1:0]    drop_cnt;

  always #5 clk = ~clk;

  pingpong_frame_arbiter #(
    .FRAME_PIXELS (FP),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .DROP_CNT_W   (DCW)
  ) dut (
    .cam_pclk         (clk),
    .rst              (rst),
    .cmos_frame_vsync (vsync),
    .cmos_frame_href  (href),
    .cmos_frame_clken (clken),
    .cmos_frame_data  (pix),
    .ram_wr_en_0      (wr_en_0),
    .ram_wr_en_1      (wr_en_1),
    .ram_wr_addr      (wr_addr),
    .ram_wr_data      (wr_data),
    .ram_rd_sel       (rd_sel),
    .ram_rd_addr      (rd_addr),
    .rd_start         (rd_start),
    .rd_en            (rd_en),
    .rd_busy          (rd_busy),
    .frame_valid      (frame_valid),
    .frame_err        (frame_err),
    .frame_drop_cnt   (drop_cnt)
  );

  typedef struct packed {
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total    = 0;
  int  bad      = 0;
  int  err_seen = 0;

  function automatic logic [DCW-1:0] exp_drop(input int n);
`ifdef PINGPONG_DROP_CNT_EN
    return DCW'(n);
`else
    return DCW'(n * 0);
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Write monitor: every enabled write must match the head of the expected-write queue.
  always @(negedge clk) begin : mon
    wr_t e;
    if (wr_en_0 || wr_en_1) begin
      chk("wr_en_onehot", 64'(wr_en_0 & wr_en_1), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'({wr_en_1, wr_en_0}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_bank", 64'(wr_en_1), 64'(e.bank));
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
    if (frame_err) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    repeat (3) tick();
  endtask

  task automatic pixels(input int n, input logic bank, input logic [DATA_W-1:0] base);
    int  sent = 0;
    int  cyc  = 0;
    wr_t w;
    while (sent < n) begin
      href  = 1'b1;
      clken = (cyc % 7 != 6);
      pix   = DATA_W'(base + sent);
      if (clken) begin
        if (sent < FP) begin
          w.bank = bank;
          w.addr = ADDR_W'(sent);
          w.data = pix;
          exp_q.push_back(w);
        end
        sent++;
      end
      cyc++;
      tick();
    end
    href  = 1'b0;
    clken = 1'b0;
  endtask

  // Drops vsync; the third edge afterwards is the W_END decision edge.
  task automatic frame_end(input logic start_rd, input logic last_rd);
    vsync = 1'b0;
    tick();
    tick();
    rd_start = start_rd;
    rd_en    = last_rd;
    tick();
    rd_start = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic rd_begin();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic rd_words(input int from, input int upto);
    for (int a = from; a < upto; a++) begin
      chk("rd_addr_seq", 64'(rd_addr), 64'(a));
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en_0"}, 64'(wr_en_0), 64'd0);
    chk({tag, "_wr_en_1"}, 64'(wr_en_1), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_rd_sel"}, 64'(rd_sel), 64'd1);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_rd_busy"}, 64'(rd_busy), 64'd0);
    chk({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got still running required finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; pix = '0;
    rd_start = 1'b0; rd_en = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // A: good frame, reader idle -> bank 0, then swap
    frame_start(); pixels(FP, 1'b0, 16'h1000); frame_end(1'b0, 1'b0); tick();
    chk("A_frame_valid", 64'(frame_valid), 64'd1);
    chk("A_rd_busy", 64'(rd_busy), 64'd0);
    chk("A_err", 64'(err_seen), 64'd0);

    // Reader takes bank 0
    rd_begin();
    chk("rd_busy_set", 64'(rd_busy), 64'd1);
    chk("rd_sel_bank0", 64'(rd_sel), 64'd0);
    chk("rd_fv_cleared", 64'(frame_valid), 64'd0);
    rd_words(0, 20);

    // B: good frame while reader holds bank 0 -> written to bank 1, dropped
    frame_start(); pixels(FP, 1'b1, 16'h2000); frame_end(1'b0, 1'b0); tick();
    chk("B_drop", 64'(drop_cnt), 64'(exp_drop(1)));
    chk("B_fv", 64'(frame_valid), 64'd0);
    chk("B_busy", 64'(rd_busy), 64'd1);
    rd_words(20, FP);
    chk("rd_done_busy", 64'(rd_busy), 64'd0);
    chk("rd_done_addr", 64'(rd_addr), 64'(FP - 1));
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rd_en_idle_ignored", 64'(rd_addr), 64'(FP - 1));
    rd_begin();
    chk("rd_start_no_frame", 64'(rd_busy), 64'd0);

    // C: no swap happened on drop, so still bank 1; now swaps
    frame_start(); pixels(FP, 1'b1, 16'h3000); frame_end(1'b0, 1'b0); tick();
    chk("C_fv", 64'(frame_valid), 64'd1);

    // Short then long frames into bank 0: errors, no swap, valid unchanged
    frame_start(); pixels(10, 1'b0, 16'h4000); frame_end(1'b0, 1'b0); tick();
    chk("short_err", 64'(err_seen), 64'd1);
    chk("short_fv", 64'(frame_valid), 64'd1);
    frame_start(); pixels(FP + 10, 1'b0, 16'h5000); frame_end(1'b0, 1'b0); tick();
    chk("long_err", 64'(err_seen), 64'd2);
    chk("long_fv", 64'(frame_valid), 64'd1);
    chk("long_last_addr", 64'(wr_addr), 64'(FP - 1));

    // D: rd_start in the W_END cycle claims the old bank; new frame dropped
    frame_start(); pixels(FP, 1'b0, 16'h6000); frame_end(1'b1, 1'b0);
    chk("D_busy", 64'(rd_busy), 64'd1);
    chk("D_sel", 64'(rd_sel), 64'd1);
    chk("D_fv", 64'(frame_valid), 64'd0);
    tick();
    chk("D_drop", 64'(drop_cnt), 64'(exp_drop(2)));
    chk("D_err", 64'(err_seen), 64'd2);

    // E: last rd_en in the W_END cycle counts as free -> swap
    rd_words(0, FP - 1);
    frame_start(); pixels(FP, 1'b0, 16'h7000);
    chk("E_rd_addr_hold", 64'(rd_addr), 64'(FP - 1));
    frame_end(1'b0, 1'b1);
    chk("E_busy", 64'(rd_busy), 64'd0);
    chk("E_fv", 64'(frame_valid), 64'd1);
    chk("E_drop", 64'(drop_cnt), 64'(exp_drop(2)));

    // F: stale frame overwritten through the swap, not a drop
    frame_start(); pixels(FP, 1'b1, 16'h8000); frame_end(1'b0, 1'b0); tick();
    chk("F_fv", 64'(frame_valid), 64'd1);
    chk("F_drop", 64'(drop_cnt), 64'(exp_drop(2)));

    // G: reset mid-capture; no writes until a fresh vsync rise
    frame_start(); pixels(30, 1'b0, 16'h9000);
    rst = 1'b1; href = 1'b1; clken = 1'b1;
    tick(); tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    repeat (20) tick();
    href = 1'b0; clken = 1'b0; vsync = 1'b0;
    repeat (3) tick();

    // H: capture resumes in bank 0
    frame_start(); pixels(FP, 1'b0, 16'hA000); frame_end(1'b0, 1'b0); tick();
    chk("H_fv", 64'(frame_valid), 64'd1);
    chk("H_err", 64'(err_seen), 64'd2);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
